// File: rtl/shared_reg_unit_if.sv
// ============================================================================
// Module      : shared_reg_unit_if
// Description : Request/response bundle between the two processor ports and
//               the shared register unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface shared_reg_unit_if;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [4:0]  dst0;
    logic [4:0]  dst1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        stall0;
    logic        stall1;
    logic [15:0] conflict_cnt;

    // Processor side drives requests and read addresses.
    modport master (
        output op0, op1, dst0, dst1, wdata0, wdata1, rs0, rs1,
        input  rdata0, rdata1, stall0, stall1, conflict_cnt
    );

    // Register unit side answers with read data, stalls and the counter.
    modport slave (
        input  op0, op1, dst0, dst1, wdata0, wdata1, rs0, rs1,
        output rdata0, rdata1, stall0, stall1, conflict_cnt
    );
endinterface

`default_nettype wire

// File: rtl/shared_reg_unit.sv
// ============================================================================
// Module      : shared_reg_unit
// Description : 32x32 shared register file for two processor ports with
//               combinational bypassed reads, round-robin write arbitration
//               and merged atomic adds.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shared_reg_unit (
    input  wire              CLK,
    input  wire              RST,
    shared_reg_unit_if.slave bus
);

    localparam logic [1:0]  c_op_write = 2'b01;
    localparam logic [1:0]  c_op_add   = 2'b10;
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        prio_q;
    logic        prio_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    logic        act0;
    logic        act1;
    logic        add0;
    logic        add1;
    logic        conflict;
    logic        merged;
    logic        grant0;
    logic        grant1;
    logic [31:0] nv0;
    logic [31:0] nv1;

    // Request decode and arbitration; a write on a shared target loses to prio.
    always_comb begin
        act0     = 1'b0;
        act1     = 1'b0;
        add0     = 1'b0;
        add1     = 1'b0;
        conflict = 1'b0;
        merged   = 1'b0;
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (!RST) begin
            add0 = (bus.op0 == c_op_add);
            add1 = (bus.op1 == c_op_add);
            act0 = add0 || (bus.op0 == c_op_write);
            act1 = add1 || (bus.op1 == c_op_write);
        end
        if (act0 && act1 && (bus.dst0 == bus.dst1)) begin
            if (add0 && add1) begin
                merged = 1'b1;
            end else begin
                conflict = 1'b1;
            end
        end
        grant0 = act0 && !(conflict &&  prio_q);
        grant1 = act1 && !(conflict && !prio_q);
    end

    assign bus.stall0 = conflict &&  prio_q;
    assign bus.stall1 = conflict && !prio_q;
    assign bus.conflict_cnt = cnt_q;

    // Post-edge value of each port's target; merged adds share a single sum.
    always_comb begin
        nv0 = bus.wdata0;
        nv1 = bus.wdata1;
        if (merged) begin
            nv0 = regs_q[bus.dst0] + bus.wdata0 + bus.wdata1;
            nv1 = nv0;
        end else begin
            if (add0) begin
                nv0 = regs_q[bus.dst0] + bus.wdata0;
            end
            if (add1) begin
                nv1 = regs_q[bus.dst1] + bus.wdata1;
            end
        end
    end

    // Bypassed reads: only granted requests forward their result.
    always_comb begin
        bus.rdata0 = regs_q[bus.rs0];
        bus.rdata1 = regs_q[bus.rs1];
        if (bus.rs0 == 5'd0) begin
            bus.rdata0 = 32'd0;
        end else if (grant0 && (bus.rs0 == bus.dst0)) begin
            bus.rdata0 = nv0;
        end else if (grant1 && (bus.rs0 == bus.dst1)) begin
            bus.rdata0 = nv1;
        end
        if (bus.rs1 == 5'd0) begin
            bus.rdata1 = 32'd0;
        end else if (grant0 && (bus.rs1 == bus.dst0)) begin
            bus.rdata1 = nv0;
        end else if (grant1 && (bus.rs1 == bus.dst1)) begin
            bus.rdata1 = nv1;
        end
    end

    // Next architectural state: commits, prio rotation, saturating counter.
    always_comb begin
        regs_d = regs_q;
        prio_d = prio_q ^ conflict;
        cnt_d  = cnt_q;
        if (grant0 && (bus.dst0 != 5'd0)) begin
            regs_d[bus.dst0] = nv0;
        end
        if (grant1 && (bus.dst1 != 5'd0)) begin
            regs_d[bus.dst1] = nv1;
        end
        if (conflict && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + 16'd1;
        end
        regs_d[0] = 32'd0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            prio_q <= 1'b0;
            cnt_q  <= 16'd0;
        end else begin
            regs_q <= regs_d;
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/shared_reg_unit.md
# shared_reg_unit

Responder for the shared-register interface between the two pipelined processors. It owns a 32×32 shared register file. It serves one combinational read and one write-class request per processor port each cycle, and arbitrates conflicting writes round-robin by stalling the losing port. It also provides an atomic add so that concurrent accumulations into one shared register are never lost. It sits at top level between the two processor instances, in place of direct shared-register storage.

## Interface

Parameters:
- none; register count fixed at 32, data width fixed at 32, ports fixed at 2.

Ports:
- `CLK`  in  1  system clock. One clock; reset is synchronous and active-high.
- `RST`  in  1  synchronous, active-high reset.
- `op0`, `op1`  in  2  request opcode per port: 2'b00 none, 2'b01 write, 2'b10 atomic add, 2'b11 treated as none.
- `dst0`, `dst1`  in  5  target register of the write or add.
- `wdata0`, `wdata1`  in  32  write value, or addend for an add.
- `rs0`, `rs1`  in  5  read register number.
- `rdata0`, `rdata1`  out  32  read data, with bypass.
- `stall0`, `stall1`  out  1  port request not granted this cycle; the processor must freeze and re-present the same request.
- `conflict_cnt`  out  16  number of cycles in which a stall was issued, saturating.

## Operation

- Register 0 reads as 0. Writes and adds to register 0 are accepted and granted but discarded.
- A request is active when op is 01 or 10 and `RST` is low.

Grant rules, evaluated combinationally each cycle:
- Only one port active: granted.
- Both active, `dst0` != `dst1`: both granted.
- Both active, same dst, both adds: both granted, merged. r[dst] <= r[dst] + wdata0 + wdata1, mod 2^32.
- Both active, same dst, any write involved: only the priority port is granted. The other port gets stall=1.

Round-robin pointer `prio`:
- 1 bit; 0 means port 0 has priority.
- Reset value 0.
- Toggles on each clock edge where a conflict stall was issued, so the stalled port wins its retry.
- Unchanged otherwise.

Commit:
- Granted writes set r[dst] <= wdata.
- Granted adds set r[dst] <= r[dst] + wdata, mod 2^32, no overflow flag.
- Commit happens at the rising edge of `CLK`.
- A stalled request has no effect on state.

Read bypass:
- `rdataN` = 0 if `rsN`==0.
- Otherwise, if `rsN` equals a granted dst this cycle, `rdataN` is the value that dst will hold after the edge (the write value, or the add/merged sum).
- Otherwise `rdataN` = r[`rsN`].
- Stalled requests are never bypassed.

Counter:
- `conflict_cnt` increments by 1 on each edge where `stall0`|`stall1` was 1.
- It saturates at 16'hFFFF.

Reset, while `RST`=1 at an edge:
- All r[ ] are cleared to 0, `prio` to 0, and `conflict_cnt` to 0.
- Requests present during a reset cycle are ignored.
- `stall0`/`stall1` are forced 0 while `RST`=1.
- `rdataN` during reset reflects the pre-reset contents, with no bypass.

## Timing

- Read latency 0: combinational from `rs`, `op`, `dst`, and `wdata`.
- Write/add latency: architectural state is updated at the first rising edge after a granted request. It is visible through r[] from the next cycle and through bypass in the same cycle.
- Stall is combinational in the same cycle as the request.
- At most one stall cycle per conflict. With a held request, the loser is guaranteed a grant on the next cycle, unless the winner issues a new conflicting request to the same dst and priority has rotated back. `prio` rotation guarantees alternation under persistent conflict.
- Reset asserted mid-conflict: the pending loser request is dropped, and no stall is asserted on the cycle after reset deassertion unless a new conflict occurs.
- All state is registered on `CLK`. There are no latches, and no asynchronous paths from `RST`.

## Test plan

- Single write, port 0: write dst=26, wdata=5. Next cycle, `rs1`=26 gives `rdata1`=5. Both stalls stay 0 and `conflict_cnt`=0.
- Merged adds: r26=10; both ports add to 26 with 3 and 4 in the same cycle. r26=17, no stall, and `rdata0`=17 by bypass during the request cycle.
- Write conflict with round-robin, after reset: both write 26 (port 0: 1, port 1: 2). Cycle 1 grants port 0 and `stall1`=1. Cycle 2 grants port 1, so r26=2, and `conflict_cnt`=1. Repeat the same pair: port 1 wins first (`stall0`=1), and final r26=1.
- Different destinations: port 0 writes r5=7 and port 1 adds 9 to r6=1 in the same cycle. r5=7, r6=10, no stall.
- Register 0 and wrap: write r0=99 reads back 0. Add 1 to r3=32'hFFFFFFFF gives r3=0.
- Reset mid-operation: assert `RST` during a conflict cycle. All r=0, `conflict_cnt`=0, `prio`=0, stalls 0. The first request after reset commits normally.
